// File: rtl/td4_pkg.sv
// td4_pkg: opcode, adder-source select and sequencer state encodings for the TD4 core.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package td4_pkg;

    // 4-bit opcodes (rom_data[7:4])
    localparam logic [3:0] OP_ADD_A    = 4'b0000;
    localparam logic [3:0] OP_MOV_AB   = 4'b0001;  // MOV A,B
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_BA   = 4'b0100;  // MOV B,A
    localparam logic [3:0] OP_ADD_B    = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    // Adder source select
    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/td4_decoder.sv
// td4_decoder: maps a TD4 opcode plus the carry flag to adder source and load enables.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs are ungated decode, the caller qualifies them.
//
// Ports:
//   opcode  in  4  instruction bits [7:4]
//   carry   in  1  registered carry flag (JNC condition)
//   sel     out 2  adder source select
//   ld_a, ld_b, ld_out, ld_pc  out 1  raw write enables
module td4_decoder
    import td4_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       carry,
    output logic [1:0] sel,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       ld_pc
);

    always_comb begin
        sel    = SEL_ZERO;
        ld_a   = 1'b0;
        ld_b   = 1'b0;
        ld_out = 1'b0;
        ld_pc  = 1'b0;
        case (opcode)
            OP_ADD_A:    begin sel = SEL_A;    ld_a   = 1'b1; end
            OP_ADD_B:    begin sel = SEL_B;    ld_b   = 1'b1; end
            OP_MOV_A_IM: begin sel = SEL_ZERO; ld_a   = 1'b1; end
            OP_MOV_B_IM: begin sel = SEL_ZERO; ld_b   = 1'b1; end
            OP_MOV_AB:   begin sel = SEL_B;    ld_a   = 1'b1; end
            OP_MOV_BA:   begin sel = SEL_A;    ld_b   = 1'b1; end
            OP_IN_A:     begin sel = SEL_IN;   ld_a   = 1'b1; end
            OP_IN_B:     begin sel = SEL_IN;   ld_b   = 1'b1; end
            OP_OUT_B:    begin sel = SEL_B;    ld_out = 1'b1; end
            OP_OUT_IM:   begin sel = SEL_ZERO; ld_out = 1'b1; end
            OP_JMP:      begin sel = SEL_ZERO; ld_pc  = 1'b1; end
            OP_JNC:      begin sel = SEL_ZERO; ld_pc  = ~carry; end
            default:     begin sel = SEL_ZERO; end
        endcase
    end

endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4 program counter, carry flag, run/idle/halt FSM and enable gating.
// Latency: fetch/decode combinational; the instruction at PC commits on the next edge.
// Backpressure: run low (or HALT) stalls PC and carry; step (TD4_STEP_EN) executes one.
//
// Optional feature macro: TD4_STEP_EN adds the `step` port for single-stepping from IDLE.
// Ports:
//   CLK, N_RESET       clock, synchronous active-low reset
//   run, step          continuous-run level, single-step pulse (TD4_STEP_EN only)
//   rom_addr/rom_data  instruction ROM address (= PC) and fetched byte
//   alu_carry          adder carry-out of the current instruction
//   sel, imm           adder source select and immediate (ungated decode)
//   ld_a/ld_b/ld_out/ld_pc  write enables, qualified by exec
//   carry, halted      registered carry flag, HALT state indicator
module td4_sequencer
    import td4_pkg::*;
(
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       run,
`ifdef TD4_STEP_EN
    input  logic       step,
`endif
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       alu_carry,
    output logic [1:0] sel,
    output logic [3:0] imm,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       ld_pc,
    output logic       carry,
    output logic       halted
);

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic       carry_q, carry_d;

    logic       dec_ld_a, dec_ld_b, dec_ld_out, dec_ld_pc;
    logic       exec;
    logic       jump_self;

    td4_decoder u_dec (
        .opcode (rom_data[7:4]),
        .carry  (carry_q),
        .sel    (sel),
        .ld_a   (dec_ld_a),
        .ld_b   (dec_ld_b),
        .ld_out (dec_ld_out),
        .ld_pc  (dec_ld_pc)
    );

    assign imm = rom_data[3:0];

    always_comb begin
`ifdef TD4_STEP_EN
        // run wins over step in IDLE: the cycle goes to entering RUN, not executing.
        exec = (state_q == ST_RUN) || ((state_q == ST_IDLE) && step && !run);
`else
        exec = (state_q == ST_RUN);
`endif
    end

    // An executed jump to its own address can never make progress: park in HALT.
    assign jump_self = exec && dec_ld_pc && (imm == pc_q);

    always_comb begin
        pc_d    = pc_q;
        carry_d = carry_q;
        if (exec) begin
            pc_d    = dec_ld_pc ? imm : pc_q + 4'd1;
            carry_d = alu_carry;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (jump_self)  state_d = ST_HALT;
                else if (run)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (jump_self)  state_d = ST_HALT;
                else if (!run)  state_d = ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
        end
    end

    // Enables are also masked by reset so nothing writes the datapath during reset.
    assign ld_a     = dec_ld_a   && exec && N_RESET;
    assign ld_b     = dec_ld_b   && exec && N_RESET;
    assign ld_out   = dec_ld_out && exec && N_RESET;
    assign ld_pc    = dec_ld_pc  && exec && N_RESET;

    assign rom_addr = pc_q;
    assign carry    = carry_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_sequencer.sv
module tb_td4_sequencer;

    logic       CLK = 1'b0;
    logic       N_RESET;
    logic       run;
`ifdef TD4_STEP_EN
    logic       step;
`endif
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       alu_carry;
    logic [1:0] sel;
    logic [3:0] imm;
    logic       ld_a, ld_b, ld_out, ld_pc;
    logic       carry, halted;

    logic [7:0] rom [16];
    logic       use_rom;
    logic [7:0] rom_force;

    int n_pass  = 0;
    int n_total = 0;

    assign rom_data = use_rom ? rom[rom_addr] : rom_force;

    always #5 CLK = ~CLK;

    td4_sequencer dut (
        .CLK       (CLK),
        .N_RESET   (N_RESET),
        .run       (run),
`ifdef TD4_STEP_EN
        .step      (step),
`endif
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .alu_carry (alu_carry),
        .sel       (sel),
        .imm       (imm),
        .ld_a      (ld_a),
        .ld_b      (ld_b),
        .ld_out    (ld_out),
        .ld_pc     (ld_pc),
        .carry     (carry),
        .halted    (halted)
    );

    typedef struct {
        logic [7:0] instr;
        logic       ac;    // alu_carry driven this cycle
        logic [3:0] pc;    // expected rom_addr
        logic       cy;    // expected carry flag
        logic [1:0] sel;
        logic [3:0] ldv;   // {ld_a, ld_b, ld_out, ld_pc}
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; inputs are driven and outputs sampled around the negedge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        N_RESET = 1'b0;
        run     = 1'b0;
        tick();
        N_RESET = 1'b1;
    endtask

    function automatic logic [3:0] lds();
        return {ld_a, ld_b, ld_out, ld_pc};
    endfunction

    initial begin
        vecs[0]  = '{8'h01, 1'b1, 4'd0,  1'b0, 2'b00, 4'b1000};
        vecs[1]  = '{8'hE5, 1'b0, 4'd1,  1'b1, 2'b11, 4'b0000};
        vecs[2]  = '{8'hE5, 1'b0, 4'd2,  1'b0, 2'b11, 4'b0001};
        vecs[3]  = '{8'h5A, 1'b1, 4'd5,  1'b0, 2'b01, 4'b0100};
        vecs[4]  = '{8'h37, 1'b0, 4'd6,  1'b1, 2'b11, 4'b1000};
        vecs[5]  = '{8'h72, 1'b1, 4'd7,  1'b0, 2'b11, 4'b0100};
        vecs[6]  = '{8'h10, 1'b1, 4'd8,  1'b1, 2'b01, 4'b1000};
        vecs[7]  = '{8'h40, 1'b0, 4'd9,  1'b1, 2'b00, 4'b0100};
        vecs[8]  = '{8'h20, 1'b0, 4'd10, 1'b0, 2'b10, 4'b1000};
        vecs[9]  = '{8'h60, 1'b1, 4'd11, 1'b0, 2'b10, 4'b0100};
        vecs[10] = '{8'h90, 1'b0, 4'd12, 1'b1, 2'b01, 4'b0010};
        vecs[11] = '{8'hB3, 1'b0, 4'd13, 1'b0, 2'b11, 4'b0010};
        vecs[12] = '{8'hFA, 1'b1, 4'd14, 1'b0, 2'b11, 4'b0001};
        vecs[13] = '{8'h80, 1'b0, 4'd10, 1'b1, 2'b11, 4'b0000};
        vecs[14] = '{8'hC0, 1'b0, 4'd11, 1'b0, 2'b11, 4'b0000};

        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        use_rom   = 1'b0;
        rom_force = 8'h01;
        alu_carry = 1'b1;
        run       = 1'b1;
        N_RESET   = 1'b0;
`ifdef TD4_STEP_EN
        step      = 1'b0;
`endif
        @(negedge CLK);

        // Reset state, with run and an ADD A instruction present during reset
        N_RESET = 1'b0;
        run     = 1'b1;
        tick();
        check("reset_state", {28'd0, rom_addr}, 32'd0);
        check("reset_flags", {30'd0, carry, halted}, 32'd0);
        check("reset_ld", {28'd0, lds()}, 32'd0);

        // Decode table: enter RUN, then one instruction per cycle
        N_RESET = 1'b1;
        run     = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            rom_force = vecs[i].instr;
            alu_carry = vecs[i].ac;
            #1;
            check($sformatf("vec%0d", i),
                  {17'd0, rom_addr, carry, sel, imm, lds()},
                  {17'd0, vecs[i].pc, vecs[i].cy, vecs[i].sel, vecs[i].instr[3:0], vecs[i].ldv});
            tick();
        end

        // All-NOP ROM: PC wraps 15 -> 0, no enables, carry tracks alu_carry
        use_rom = 1'b1;
        do_reset();
        run = 1'b1;
        tick();
        begin
            logic prev_ac;
            prev_ac = 1'b0;
            for (int i = 0; i < 17; i++) begin
                alu_carry = ((i % 3) == 0);
                #1;
                check($sformatf("nop_cycle%0d", i),
                      {23'd0, rom_addr, carry, lds()},
                      {23'd0, 4'(i % 16), prev_ac, 4'b0000});
                prev_ac = alu_carry;
                tick();
            end
        end

        // run falling: instruction in flight completes, then PC holds
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        check("run_drop_pc", {28'd0, rom_addr}, 32'd3);
        tick();
        tick();
        check("idle_hold_pc", {28'd0, rom_addr}, 32'd3);

        // Jump-to-self at address 15 halts; run toggling has no effect
        rom[15] = 8'hFF;
        do_reset();
        run = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("halt_jmp_seen", {27'd0, rom_addr, ld_pc}, {27'd0, 4'd15, 1'b1});
        check("halt_not_yet", {31'd0, halted}, 32'd0);
        tick();
        check("halt_entered", {27'd0, rom_addr, halted}, {27'd0, 4'd15, 1'b1});
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            tick();
        end
        check("halt_sticky", {23'd0, rom_addr, halted, lds()}, {23'd0, 4'd15, 1'b1, 4'b0000});
        rom[15] = 8'h80;

        // Reset mid-run at PC 9 with carry set
        rom[9] = 8'h01;
        do_reset();
        run       = 1'b1;
        alu_carry = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        check("midrun_before", {27'd0, rom_addr, carry}, {27'd0, 4'd9, 1'b1});
        check("midrun_ld_a", {31'd0, ld_a}, 32'd1);
        N_RESET = 1'b0;
        #1;
        check("reset_forces_ld", {28'd0, lds()}, 32'd0);
        tick();
        N_RESET = 1'b1;
        run     = 1'b0;
        check("midrun_after", {26'd0, rom_addr, carry, halted}, 32'd0);
        tick();
        check("midrun_idle", {28'd0, rom_addr}, 32'd0);
        rom[9] = 8'h80;

`ifdef TD4_STEP_EN
        // Single-step from IDLE: three pulses advance PC exactly three times
        do_reset();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        check("step_three", {28'd0, rom_addr}, 32'd3);
        // step together with run: enter RUN without executing
        step = 1'b1;
        run  = 1'b1;
        tick();
        step = 1'b0;
        check("step_run_no_adv", {28'd0, rom_addr}, 32'd3);
        tick();
        check("step_run_running", {28'd0, rom_addr}, 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
